par_note_player: RTL
====================

# par_note_player

Memory-mapped note-playback responder on the external parallel interface of the picoVersat top level. The CPU writes note words (half-period, duration) through the parallel bus into an internal FIFO. A playback state machine pops notes and drives a square-wave `snd` output for the programmed duration. It answers the bus from the responder side: address, write data and strobes come in, read data goes out.

## Interface
Parameters:
- `DATA_W`, 32: bus data width.
- `ADDR_W`, 13: CPU address width; the bus address port is `ADDR_W-1` bits, and only `par_addr[1:0]` is decoded.
- `FIFO_DEPTH`, 8: note FIFO entries, power of two, 2..128.
- `TICK_RST`, 49999: reset value of the TICK register (1 ms at 50 MHz).

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `par_addr` input ADDR_W-1: register select.
- `par_wdata` input DATA_W: write data, connected to the top-level `par_out`.
- `par_we` input 1: write strobe; one write per cycle high.
- `par_re` input 1: read strobe.
- `par_rdata` output DATA_W: read data, connected to the top-level `par_in`; combinational from `par_addr`; 0 when `par_re`=0.
- `snd` output 1: square-wave audio.
- `playing` output 1: high while the FSM is in LOAD or PLAY.

## Operation
Register map (`par_addr[1:0]`):
- 0 NOTE, write: push `{dur[31:16], period[15:0]}`. Reads return 0.
- 1 STATUS, read:
  - bit0: empty.
  - bit1: full.
  - bit2: playing.
  - bit3: overflow, sticky.
  - bits[11:4]: FIFO count.
- 1 STATUS, write:
  - bit0=1: flush.
  - bit1=1: clear overflow.
- 2 CTRL, read/write: bit0 enable. Other bits read 0.
- 3 TICK, read/write: bits[23:0], prescaler terminal value.

FIFO rules:
- A write to NOTE while full is dropped and sets overflow. The exception is a pop in the same cycle: the push is then accepted and count is unchanged.
- Flush empties the FIFO, aborts the current note and forces IDLE.
- If flush and a NOTE push could coincide, flush wins.

FSM states IDLE, LOAD, PLAY:
- IDLE → LOAD when enable=1 and the FIFO is non-empty.
- LOAD:
  - Pops the head into `cur_period` and `cur_dur`.
  - Clears the half-period counter, the prescaler and `snd`.
  - If the popped dur=0, the next state is LOAD when the FIFO is still non-empty, otherwise IDLE.
  - Otherwise the next state is PLAY.
- PLAY, half-period counter `hp`:
  - When period≠0, `hp` increments each cycle. At `hp==period-1`, `snd` toggles and `hp` returns to 0.
  - When period=0 the note is a rest: `snd` is held at 0.
- PLAY, prescaler `ps`:
  - `ps` increments each cycle; at `ps==TICK`, a tick is generated and `ps` returns to 0.
  - Each tick decrements `cur_dur`.
  - When a tick takes `cur_dur` from 1 to 0, the next state is LOAD if the FIFO is non-empty, otherwise IDLE.
- enable→0 in any state: next state is IDLE, the current note is discarded, and the FIFO is retained.
- In IDLE, `snd`=0.

Width rules:
- `hp` is 16 bits; `ps` is 24 bits; count is clog2(FIFO_DEPTH)+1 bits, zero-extended into STATUS.
- A TICK write takes effect on the next prescaler compare.

## Timing
- Reset values:
  - `snd`=0, `playing`=0, `par_rdata`=0.
  - FIFO empty, overflow=0, enable=0, TICK=`TICK_RST`, FSM=IDLE.
- NOTE write in cycle N: count and empty update in N+1.
- From IDLE with enable=1 and a non-empty FIFO at cycle N: LOAD in N+1, PLAY in N+2.
- First `snd` toggle is at the end of PLAY cycle `period`.
- A note with dur=D occupies exactly D·(TICK+1) PLAY cycles. It is followed by one LOAD cycle when more notes are queued, giving one cycle of `snd`=0 between notes.
- Flush or enable→0 at cycle N: `snd`=0 and `playing`=0 from N+1.
- Reset asserted mid-note: all state returns to reset values on the next edge.
- A read in the same cycle as a write returns the pre-write value.

## Structure
- Shared package `par_note_defs`:
  - register offsets.
  - STATUS bit positions.
  - CTRL bit position.
  - FSM state encoding, 2 bits.
  - note field slices.
- Sub-module `note_fifo`, a synchronous FIFO:
  - ports: push, pop, flush, full, empty, count, data in/out.
  - simultaneous push and pop when full is accepted.
- Top of the block holds: register decode, CTRL/TICK registers, the FSM, the `hp`/`ps`/`dur` counters and the `snd` flop.

## Test plan
- Reset, then read all registers → STATUS=0x1, CTRL=0, TICK=49999, `snd`=0.
- TICK=3, push {dur=2, period=5}, enable=1 → LOAD two cycles after enable, then 8 PLAY cycles. `snd` toggles after cycle 5 only and is 0 at return to IDLE; `playing` falls immediately after.
- Push 9 notes with enable=0 (DEPTH=8) → count=8, full=1, overflow=1. Write STATUS bit1 → overflow=0, count still 8.
- Push {dur=0}, then {dur=1, period=0}, TICK=0, enable → LOAD, LOAD, one PLAY cycle with `snd`=0, then IDLE.
- FIFO full while playing. Push in the same cycle as the LOAD pop → accepted, count stays 8, overflow stays 0.
- Mid-PLAY flush → `snd`=0, `playing`=0 and empty=1 the next cycle. Repeat with enable→0 → same, but count is preserved.

Source files
------------

// File: rtl/par_note_defs.sv
// Shared definitions for the parallel-bus note player: register map, field
// positions, FSM encoding and note word slicing.
package par_note_defs;

    localparam logic [1:0] REG_NOTE   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_TICK   = 2'd3;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_PLAYING = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 8;

    // STATUS write command bits
    localparam int STAT_FLUSH   = 0;
    localparam int STAT_CLR_OVF = 1;

    localparam int CTRL_EN = 0;

    localparam int NOTE_W   = 32;
    localparam int PERIOD_W = 16;
    localparam int DUR_W    = 16;
    localparam int TICK_W   = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    function automatic logic [PERIOD_W-1:0] note_period(input logic [NOTE_W-1:0] w);
        return w[PERIOD_W-1:0];
    endfunction

    function automatic logic [DUR_W-1:0] note_dur(input logic [NOTE_W-1:0] w);
        return w[NOTE_W-1:NOTE_W-DUR_W];
    endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous show-ahead FIFO for note words; a push while full is accepted
// when a pop happens in the same cycle, and flush overrides everything.
module note_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && (!full || pop_ok) && !flush;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/par_note_player.sv
// Parallel-bus note player: register decode, CTRL/TICK, playback FSM and the
// half-period / prescaler / duration counters driving the square-wave output.
module par_note_player
    import par_note_defs::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 13,
    parameter int FIFO_DEPTH = 8,
    parameter int TICK_RST   = 49999
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-2:0] par_addr,
    input  logic [DATA_W-1:0] par_wdata,
    input  logic              par_we,
    input  logic              par_re,
    output logic [DATA_W-1:0] par_rdata,
    output logic              snd,
    output logic              playing
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t              state_reg, state_next;
    logic                enable_reg;
    logic [TICK_W-1:0]   tick_reg;
    logic                overflow_reg;
    logic [PERIOD_W-1:0] per_reg, per_next;
    logic [DUR_W-1:0]    dur_reg, dur_next;
    logic [PERIOD_W-1:0] hp_reg, hp_next;
    logic [TICK_W-1:0]   ps_reg, ps_next;
    logic                snd_reg, snd_next;

    logic [1:0]        reg_sel;
    logic              wr_note, wr_status, wr_ctrl, wr_tick;
    logic              flush, clr_ovf, ctrl_off, stop;
    logic              pop, tick, push_drop;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [NOTE_W-1:0] head;
    logic              unused_bits;

    assign reg_sel     = par_addr[1:0];
    assign wr_note     = par_we && (reg_sel == REG_NOTE);
    assign wr_status   = par_we && (reg_sel == REG_STATUS);
    assign wr_ctrl     = par_we && (reg_sel == REG_CTRL);
    assign wr_tick     = par_we && (reg_sel == REG_TICK);
    assign flush       = wr_status && par_wdata[STAT_FLUSH];
    assign clr_ovf     = wr_status && par_wdata[STAT_CLR_OVF];
    assign ctrl_off    = wr_ctrl && !par_wdata[CTRL_EN];
    // Disabling takes effect on the write cycle itself so the output is quiet next cycle
    assign stop        = flush || ctrl_off || !enable_reg;
    assign push_drop   = wr_note && fifo_full && !pop && !flush;
    assign unused_bits = ^{par_addr, par_wdata};

    assign snd     = snd_reg;
    assign playing = (state_reg != ST_IDLE);

    note_fifo #(
        .WIDTH (NOTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_note),
        .pop   (pop),
        .flush (flush),
        .din   (par_wdata[NOTE_W-1:0]),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        par_rdata = '0;
        if (par_re) begin
            case (reg_sel)
                REG_STATUS: begin
                    par_rdata[STAT_EMPTY]                   = fifo_empty;
                    par_rdata[STAT_FULL]                    = fifo_full;
                    par_rdata[STAT_PLAYING]                 = playing;
                    par_rdata[STAT_OVF]                     = overflow_reg;
                    par_rdata[STAT_CNT_LSB +: STAT_CNT_W]   = STAT_CNT_W'(fifo_count);
                end
                REG_CTRL: par_rdata[CTRL_EN]     = enable_reg;
                REG_TICK: par_rdata[TICK_W-1:0]  = tick_reg;
                default:  par_rdata              = '0;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        per_next   = per_reg;
        dur_next   = dur_reg;
        hp_next    = hp_reg;
        ps_next    = ps_reg;
        snd_next   = snd_reg;
        pop        = 1'b0;
        tick       = (ps_reg == tick_reg);
        case (state_reg)
            ST_IDLE: begin
                snd_next = 1'b0;
                if (!fifo_empty) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                pop      = 1'b1;
                per_next = note_period(head);
                dur_next = note_dur(head);
                hp_next  = '0;
                ps_next  = '0;
                snd_next = 1'b0;
                // Zero-length notes are skipped; count still includes the head being popped
                if (note_dur(head) == '0) begin
                    state_next = (fifo_count > CNT_W'(1)) ? ST_LOAD : ST_IDLE;
                end else begin
                    state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (per_reg != '0) begin
                    if (hp_reg == per_reg - PERIOD_W'(1)) begin
                        hp_next  = '0;
                        snd_next = !snd_reg;
                    end else begin
                        hp_next = hp_reg + PERIOD_W'(1);
                    end
                end else begin
                    snd_next = 1'b0;
                end
                if (tick) begin
                    ps_next  = '0;
                    dur_next = dur_reg - DUR_W'(1);
                    if (dur_reg == DUR_W'(1)) begin
                        state_next = fifo_empty ? ST_IDLE : ST_LOAD;
                        snd_next   = 1'b0;
                    end
                end else begin
                    ps_next = ps_reg + TICK_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (stop) begin
            state_next = ST_IDLE;
            pop        = 1'b0;
            snd_next   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            enable_reg   <= 1'b0;
            tick_reg     <= TICK_W'(TICK_RST);
            overflow_reg <= 1'b0;
            per_reg      <= '0;
            dur_reg      <= '0;
            hp_reg       <= '0;
            ps_reg       <= '0;
            snd_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            per_reg   <= per_next;
            dur_reg   <= dur_next;
            hp_reg    <= hp_next;
            ps_reg    <= ps_next;
            snd_reg   <= snd_next;
            if (wr_ctrl) begin
                enable_reg <= par_wdata[CTRL_EN];
            end
            if (wr_tick) begin
                tick_reg <= par_wdata[TICK_W-1:0];
            end
            if (push_drop) begin
                overflow_reg <= 1'b1;
            end else if (clr_ovf) begin
                overflow_reg <= 1'b0;
            end
        end
    end

endmodule
